// File: rtl/merge_stream_rr_pkg.sv
// Shared constants and types for the round-robin packet merger.
// Port count, port-index width and the two-state FSM encoding.
package merge_stream_rr_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  function automatic logic [PORT_W-1:0] port_inc(
    input logic [PORT_W-1:0] p
  );
    return PORT_W'(p + 1'b1);
  endfunction

endpackage

// File: rtl/merge_stream_obuf.sv
// Two-entry valid/ready skid buffer on the merged output.
// in_ready depends only on local state, never on out_ready.
module merge_stream_obuf #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         head_v;
  logic         skid_v;
  logic [W-1:0] head_d;
  logic [W-1:0] skid_d;
  logic         push;
  logic         pop;

  assign in_ready  = !skid_v;
  assign push      = in_valid && in_ready;
  assign pop       = head_v && out_ready;
  assign out_valid = head_v;
  assign out_data  = head_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      head_d <= '0;
      skid_d <= '0;
    end else if (clear) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop) begin
      if (skid_v) begin
        head_d <= skid_d;
        skid_v <= 1'b0;
      end else begin
        head_v <= push;
        if (push) head_d <= in_data;
      end
    end else if (push) begin
      // skid only fills when the head is stalled
      if (!head_v) begin
        head_v <= 1'b1;
        head_d <= in_data;
      end else begin
        skid_v <= 1'b1;
        skid_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/merge_stream_rr.sv
// Four-input packet merger with round-robin arbitration.
// Locks onto one port per packet; releases on the tlast beat.
module merge_stream_rr
  import merge_stream_rr_pkg::*;
#(
  parameter int                   WIDTH       = 16,
  parameter logic [NUM_PORTS-1:0] ACTIVE_MASK = 4'b1111
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] i0_tdata,
  input  logic             i0_tlast,
  input  logic             i0_tvalid,
  output logic             i0_tready,
  input  logic [WIDTH-1:0] i1_tdata,
  input  logic             i1_tlast,
  input  logic             i1_tvalid,
  output logic             i1_tready,
  input  logic [WIDTH-1:0] i2_tdata,
  input  logic             i2_tlast,
  input  logic             i2_tvalid,
  output logic             i2_tready,
  input  logic [WIDTH-1:0] i3_tdata,
  input  logic             i3_tlast,
  input  logic             i3_tvalid,
  output logic             i3_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [1:0]       o_src
);

  localparam int BW = WIDTH + PORT_W + 1;

  logic [NUM_PORTS-1:0] in_valid;
  logic [NUM_PORTS-1:0] in_last;
  logic [WIDTH-1:0]     in_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] rdy;

  state_t              state;
  logic [PORT_W-1:0]   grant;
  logic [PORT_W-1:0]   rr_ptr;
  logic [PORT_W-1:0]   pick;
  logic                found;
  logic                busy;
  logic                sel_valid;
  logic                sel_last;
  logic                buf_ready;
  logic                push;
  logic [BW-1:0]       buf_in;
  logic [BW-1:0]       buf_out;

  // inactive ports are masked here so they can never win
  assign in_valid = {i3_tvalid, i2_tvalid, i1_tvalid, i0_tvalid}
                  & ACTIVE_MASK;
  assign in_last  = {i3_tlast, i2_tlast, i1_tlast, i0_tlast};
  assign in_data[0] = i0_tdata;
  assign in_data[1] = i1_tdata;
  assign in_data[2] = i2_tdata;
  assign in_data[3] = i3_tdata;

  always_comb begin
    logic [PORT_W-1:0] idx;
    found = 1'b0;
    pick  = rr_ptr;
    idx   = rr_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PORT_W'(rr_ptr + PORT_W'(i));
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign busy      = (state == ST_BUSY);
  assign sel_valid = in_valid[grant];
  assign sel_last  = in_last[grant];
  assign push      = busy && sel_valid && buf_ready;
  assign buf_in    = {grant, sel_last, in_data[grant]};

  always_comb begin
    rdy = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      rdy[k] = busy && (grant == PORT_W'(k))
             && buf_ready && ACTIVE_MASK[k];
    end
  end

  assign i0_tready = rdy[0];
  assign i1_tready = rdy[1];
  assign i2_tready = rdy[2];
  assign i3_tready = rdy[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else if (clear) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (found) begin
            grant <= pick;
            state <= ST_BUSY;
          end
        end
        (state == ST_BUSY): begin
          if (push && sel_last) begin
            state  <= ST_IDLE;
            rr_ptr <= port_inc(grant);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  merge_stream_obuf #(
    .W (BW)
  ) u_obuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (busy && sel_valid),
    .in_ready  (buf_ready),
    .in_data   (buf_in),
    .out_valid (o_tvalid),
    .out_ready (o_tready),
    .out_data  (buf_out)
  );

  assign o_src   = buf_out[BW-1 -: PORT_W];
  assign o_tlast = buf_out[WIDTH];
  assign o_tdata = buf_out[WIDTH-1:0];

endmodule

// File: doc/merge_stream_rr.md
MERGE_STREAM_RR -- requirements
Module: merge_stream_rr

Interface
REQ-001 Parameter WIDTH, 16, data width of every stream.
REQ-002 Parameter ACTIVE_MASK, 4'b1111, bit k set = input port k is used; clear bits are never granted.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous flush, active-high.
REQ-006 iK_tdata/iK_tlast/iK_tvalid  input  WIDTH/1/1  input stream K, K=0..3.
REQ-007 iK_tready  output  1  input stream K ready, K=0..3.
REQ-008 o_tdata/o_tlast/o_tvalid  output  WIDTH/1/1  merged output stream.
REQ-009 o_tready  input  1  merged output ready.
REQ-010 o_src  output  2  index of the input port that supplied the current o_tdata beat.

Function
REQ-011 The block shall merge whole packets (delimited by tlast) from the four inputs onto one output and shall never interleave beats of different packets.
REQ-012 The FSM shall have two states: IDLE (arbitrate) and BUSY (locked to the granted port).
REQ-013 In IDLE, the FSM shall search ports rr_ptr, rr_ptr+1, ... mod 4, select the first port with ACTIVE_MASK set and tvalid high, register it as grant, and enter BUSY on the next edge; no input is accepted in IDLE.
REQ-014 In BUSY, only i<grant>_tready may be high, and it shall be high exactly when the output buffer can accept a beat.
REQ-015 When a beat with tlast=1 is accepted in BUSY, the FSM shall return to IDLE and set rr_ptr to (grant+1) mod 4 on the same edge.
REQ-016 Every iK_tready for an inactive port (ACTIVE_MASK bit clear) shall be constant 0.
REQ-017 The output buffer shall be a 2-entry skid FIFO; an input beat accepted on edge N shall be visible on o_tvalid after edge N.
REQ-018 With o_tready held high, BUSY shall sustain one beat per cycle, and each packet shall cost exactly one arbitration bubble cycle.
REQ-019 o_tdata, o_tlast and o_src shall be held stable while o_tvalid=1 and o_tready=0.
REQ-020 If no active port is valid, the block shall stay in IDLE and leave rr_ptr unchanged.
REQ-021 If tvalid drops mid-packet on the granted port, the block shall remain in BUSY and wait; it shall not re-arbitrate.
REQ-022 If the output buffer is full, all iK_tready shall be 0.
REQ-023 clear shall force IDLE, set rr_ptr=0, empty the output buffer and deassert all tready on the next edge; a packet in flight is truncated with no tlast emitted, and this is intended behaviour.
REQ-024 clear shall take priority over simultaneous tlast acceptance.

Reset
REQ-025 Asserting reset_n=0 shall immediately force: state IDLE, rr_ptr=0, grant=0, buffer empty, o_tvalid=0, o_tdata=0, o_tlast=0, o_src=0, and all iK_tready=0.
REQ-026 Reset deassertion mid-packet requires no recovery; upstream packets are resumed from their current beat as new packets.

Structure
REQ-027 A shared package shall hold NUM_PORTS=4, the two-value state type, and the port-index width (2).
REQ-028 The output buffer shall be a sub-module named merge_stream_obuf: a 2-entry valid/ready skid buffer of width WIDTH+3 (data, last, src).
REQ-029 Arbitration, the FSM and the input mux shall reside in merge_stream_rr; the estimated size is 150-250 lines.

Verification
REQ-030 Scenario 1: i0 sends a 3-beat packet (A1,A2,A3), o_tready=1 -> out A1..A3 on consecutive cycles, o_src=0, tlast on A3, first beat 2 cycles after i0_tvalid.
REQ-031 Scenario 2: all four ports are valid with 2-beat packets -> order of o_src is 0,1,2,3, then 0 again if refilled; 1 idle cycle between packets.
REQ-032 Scenario 3: ACTIVE_MASK=4'b0101, i1 and i3 are valid -> i1_tready and i3_tready are never 1 and no output is produced; i0 and i2 alternate.
REQ-033 Scenario 4: o_tready is toggled 1,0,0,1 during a 4-beat packet -> no beat is lost or duplicated, data is stable while stalled, and at most 2 beats are buffered.
REQ-034 Scenario 5: clear is pulsed after beat 2 of a 5-beat packet on i2 -> o_tvalid=0 next cycle, rr_ptr=0, and the next grant goes to the lowest valid active port.
REQ-035 Scenario 6: reset_n is asserted asynchronously mid-packet between clock edges -> all outputs are 0 immediately; after release, the next packet is arbitrated from port 0.
